// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with a one-second prescaler, pause/resume and expiry flag.
// Digits borrow downward seconds-ones -> minutes-tens; reaching 00:00 latches EXPIRED.
module countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] ld_mt,
    input  logic [3:0] ld_mo,
    input  logic [2:0] ld_st,
    input  logic [3:0] ld_so,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [2:0] clamp5(input logic [2:0] d);
        return (d > 3'd5) ? 3'd5 : d;
    endfunction

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [2:0]    mt_r, mt_s, st_r, st_s;
    logic [3:0]    mo_r, mo_s, so_r, so_s;
    logic          running_r, expired_r, done_r, done_s;
    logic          count_nz_s, at_one_s, tick_s;

    assign count_nz_s = (mt_r != 3'd0) || (mo_r != 4'd0) || (st_r != 3'd0) || (so_r != 4'd0);
    assign at_one_s   = (mt_r == 3'd0) && (mo_r == 4'd0) && (st_r == 3'd0) && (so_r == 4'd1);
    assign tick_s     = (presc_r == PRESC_LAST);

    // Next-state, prescaler and digit update; pause outranks load, load outranks start.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        mt_s    = mt_r;
        mo_s    = mo_r;
        st_s    = st_r;
        so_s    = so_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pause) begin
                    state_s = IDLE;
                end else if (load) begin
                    mt_s = clamp5(ld_mt);
                    mo_s = clamp9(ld_mo);
                    st_s = clamp5(ld_st);
                    so_s = clamp9(ld_so);
                end else if (start && count_nz_s) begin
                    state_s = RUN;
                    presc_s = PRESC_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (pause) begin
                    state_s = PAUSE;
                end else if (tick_s) begin
                    presc_s = PRESC_ZERO;
                    if (so_r != 4'd0) begin
                        so_s = so_r - 4'd1;
                    end else begin
                        so_s = 4'd9;
                        if (st_r != 3'd0) begin
                            st_s = st_r - 3'd1;
                        end else begin
                            st_s = 3'd5;
                            if (mo_r != 4'd0) begin
                                mo_s = mo_r - 4'd1;
                            end else begin
                                mo_s = 4'd9;
                                mt_s = mt_r - 3'd1;
                            end
                        end
                    end
                    if (at_one_s) begin
                        state_s = EXPIRED;
                        done_s  = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    presc_s = presc_r + PRESC_ONE;
                end
            end
            PAUSE: begin
                if (pause) begin
                    state_s = PAUSE;
                end else if (load) begin
                    mt_s    = clamp5(ld_mt);
                    mo_s    = clamp9(ld_mo);
                    st_s    = clamp5(ld_st);
                    so_s    = clamp9(ld_so);
                    presc_s = PRESC_ZERO;
                    state_s = IDLE;
                end else if (start && count_nz_s) begin
                    state_s = RUN;
                end else begin
                    state_s = PAUSE;
                end
            end
            EXPIRED: begin
                if (pause) begin
                    state_s = EXPIRED;
                end else if (load) begin
                    mt_s    = clamp5(ld_mt);
                    mo_s    = clamp9(ld_mo);
                    st_s    = clamp5(ld_st);
                    so_s    = clamp9(ld_so);
                    presc_s = PRESC_ZERO;
                    state_s = IDLE;
                end else begin
                    state_s = EXPIRED;
                end
            end
            default: begin
                state_s = IDLE;
                presc_s = PRESC_ZERO;
            end
        endcase
    end

    // State, digits and status flags; status flags follow the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            presc_r   <= PRESC_ZERO;
            mt_r      <= 3'd0;
            mo_r      <= 4'd0;
            st_r      <= 3'd0;
            so_r      <= 4'd0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            mt_r      <= mt_s;
            mo_r      <= mo_s;
            st_r      <= st_s;
            so_r      <= so_s;
            running_r <= (state_s == RUN);
            expired_r <= (state_s == EXPIRED);
            done_r    <= done_s;
        end
    end

    assign min_t   = mt_r;
    assign min_o   = mo_r;
    assign sec_t   = st_r;
    assign sec_o   = so_r;
    assign running = running_r;
    assign expired = expired_r;
    assign done    = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic       clk, rst, load, start, pause;
    logic [2:0] ld_mt, ld_st, min_t, sec_t;
    logic [3:0] ld_mo, ld_so, min_o, sec_o;
    logic       running, expired, done;

    int n_vec = 0;
    int n_err = 0;
    int m_state, m_sec, m_ph, m_done;
    int done_seen;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ld_mt(ld_mt), .ld_mo(ld_mo), .ld_st(ld_st), .ld_so(ld_so),
        .start(start), .pause(pause),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .running(running), .expired(expired), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int digits_of(input int secs);
        int mt, mo, st, so;
        mt = secs / 600;
        mo = (secs / 60) % 10;
        st = (secs % 60) / 10;
        so = secs % 10;
        return (mt << 11) | (mo << 7) | (st << 4) | so;
    endfunction

    function automatic int dut_digits();
        return int'({min_t, min_o, sec_t, sec_o});
    endfunction

    function automatic int load_secs();
        int mt, mo, st, so;
        mt = (ld_mt > 3'd5) ? 5 : int'(ld_mt);
        mo = (ld_mo > 4'd9) ? 9 : int'(ld_mo);
        st = (ld_st > 3'd5) ? 5 : int'(ld_st);
        so = (ld_so > 4'd9) ? 9 : int'(ld_so);
        return mt * 600 + mo * 60 + st * 10 + so;
    endfunction

    // Behavioural model: time kept as whole seconds plus RUN cycles since the last decrement.
    task automatic model_step();
        m_done = 0;
        if (m_state == S_RUN) begin
            if (pause) begin
                m_state = S_PAUSE;
            end else begin
                m_ph++;
                if (m_ph == TD) begin
                    m_ph = 0;
                    m_sec--;
                    if (m_sec == 0) begin
                        m_state = S_EXP;
                        m_done  = 1;
                    end
                end
            end
        end else if (pause) begin
            m_ph = m_ph;
        end else if (load) begin
            m_sec   = load_secs();
            m_ph    = 0;
            m_state = S_IDLE;
        end else if (start && m_sec > 0 && m_state != S_EXP) begin
            if (m_state == S_IDLE) m_ph = 0;
            m_state = S_RUN;
        end
    endtask

    task automatic compare_all();
        check_val("digits", dut_digits(), digits_of(m_sec));
        check_val("running", int'(running), (m_state == S_RUN) ? 1 : 0);
        check_val("expired", int'(expired), (m_state == S_EXP) ? 1 : 0);
        check_val("done", int'(done), m_done);
        if (done) done_seen++;
    endtask

    task automatic cyc(input logic l, input logic [2:0] mt, input logic [3:0] mo,
                       input logic [2:0] st, input logic [3:0] so, input logic s, input logic p);
        load = l; ld_mt = mt; ld_mo = mo; ld_st = st; ld_so = so; start = s; pause = p;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input int mt, input int mo, input int st, input int so);
        cyc(1'b1, 3'(mt), 4'(mo), 3'(st), 4'(so), 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cyc(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic do_pause();
        cyc(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int r;
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        ld_mt = 3'd0; ld_mo = 4'd0; ld_st = 3'd0; ld_so = 4'd0;
        m_state = S_IDLE; m_sec = 0; m_ph = 0; m_done = 0; done_seen = 0;
        @(posedge clk); #1;
        compare_all();
        rst = 1'b1;

        // 01:00 down to 00:00
        do_load(0, 1, 0, 0);
        do_start();
        check_val("start_running", int'(running), 1);
        idle_n(TD);
        check_val("first_dec", dut_digits(), digits_of(59));
        done_seen = 0;
        idle_n(60 * TD - TD + 2);
        check_val("expiry_digits", dut_digits(), 0);
        check_val("expiry_flag", int'(expired), 1);
        check_val("done_count", done_seen, 1);

        // borrow chain from 10:00, then 00:10 via pause+load
        do_load(1, 0, 0, 0);
        do_start();
        idle_n(TD);
        check_val("borrow_959", dut_digits(), digits_of(599));
        do_pause();
        do_load(0, 0, 1, 0);
        do_start();
        idle_n(TD);
        check_val("borrow_009", dut_digits(), digits_of(9));

        // clamping
        do_pause();
        do_load(7, 15, 7, 15);
        check_val("clamp_5959", dut_digits(), digits_of(3599));

        // start at 00:00 ignored
        do_load(0, 0, 0, 0);
        done_seen = 0;
        do_start();
        idle_n(3);
        check_val("zero_start_run", int'(running), 0);
        check_val("zero_start_done", done_seen, 0);

        // pause/resume accounting and pause coinciding with a tick
        do_load(0, 0, 2, 0);
        do_start();
        idle_n(2);
        do_pause();
        idle_n(10);
        do_start();
        idle_n(TD + 1);
        for (int i = 0; i < 2 * TD && m_ph != TD - 1; i++) idle_n(1);
        do_pause();
        check_val("pause_on_tick", dut_digits(), digits_of(m_sec));
        cyc(1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b1);
        check_val("pause_start_pause", int'(running), 0);
        do_start();
        idle_n(TD * 25);
        check_val("exp_after_resume", int'(expired), 1);
        do_start();
        check_val("exp_start_ign", int'(expired), 1);
        do_load(0, 0, 0, 5);
        check_val("exp_load_idle", int'(expired), 0);
        cyc(1'b1, 3'd0, 4'd0, 3'd1, 4'd2, 1'b1, 1'b0);
        check_val("ld_start_idle", int'(running), 0);
        check_val("ld_start_dig", dut_digits(), digits_of(12));

        // asynchronous reset mid-run at 03:27
        do_load(0, 3, 3, 0);
        do_start();
        for (int i = 0; i < 40 && m_sec != 207; i++) idle_n(1);
        check_val("at_0327", dut_digits(), digits_of(207));
        #2 rst = 1'b0;
        #1;
        m_state = S_IDLE; m_sec = 0; m_ph = 0; m_done = 0;
        check_val("rst_digits", dut_digits(), 0);
        check_val("rst_running", int'(running), 0);
        @(posedge clk); #1;
        compare_all();
        rst = 1'b1;
        do_start();
        check_val("rst_fsm_idle", int'(running), 0);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cyc(1'b1, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                    4'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 1'b0, 1'b0);
            end else if (r < 6) begin
                do_pause();
            end else if (r < 18) begin
                do_start();
            end else begin
                idle_n(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD countdown timer for the digital-clock lab design. It runs the opposite direction of the time-of-day up-counters. The block takes a loaded MM:SS value and decrements it once per second from an internal prescaler, borrowing across the seconds-ones, seconds-tens, minutes-ones and minutes-tens digits. When it reaches 00:00 it flags expiry. Its BCD digit outputs connect to the same seven-segment display path as the clock counters.

## Interface
- TICK_DIV, default 50000000, number of clk cycles per one-second decrement; must be ≥ 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle load strobe for the ld_* digits.
- ld_mt  input  3  minutes tens digit to load, 0–5.
- ld_mo  input  4  minutes ones digit to load, 0–9.
- ld_st  input  3  seconds tens digit to load, 0–5.
- ld_so  input  4  seconds ones digit to load, 0–9.
- start  input  1  one-cycle start or resume strobe.
- pause  input  1  one-cycle pause strobe.
- min_t  output  3  current minutes tens digit.
- min_o  output  4  current minutes ones digit.
- sec_t  output  3  current seconds tens digit.
- sec_o  output  4  current seconds ones digit.
- running  output  1  high while in state RUN.
- expired  output  1  high while in state EXPIRED.
- done  output  1  one-cycle pulse on reaching 00:00.

## Operation
- FSM states: IDLE, RUN, PAUSE, EXPIRED. Reset state is IDLE.
- Reset values: all digits 0, running=0, expired=0, done=0, prescaler 0.
- Input priority within one cycle: pause > load > start.
- IDLE:
  - load writes the digits; state stays IDLE.
  - start with a nonzero count goes to RUN and clears the prescaler.
  - start with count 00:00 is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle (tick) the count decrements by one second.
  - pause goes to PAUSE. The prescaler value is held and no decrement occurs, even if a tick coincides.
  - load and start are ignored.
- PAUSE:
  - start resumes RUN; the prescaler continues from its held value.
  - load writes the digits, clears the prescaler and goes to IDLE.
  - start with count 00:00 is ignored.
- EXPIRED:
  - start and pause are ignored.
  - load writes the digits and goes to IDLE.
- Decrement rules:
  - sec_o: 0 becomes 9 and borrows from sec_t; otherwise sec_o-1.
  - sec_t: 0 becomes 5 and borrows from min_o.
  - min_o: 0 becomes 9 and borrows from min_t.
  - min_t decrements only. Underflow below 00:00 cannot occur, because 00:00 forces EXPIRED.
- Load clamping: ld_so or ld_mo above 9 loads 9. ld_st or ld_mt above 5 loads 5. Each digit is clamped independently.
- Expiry: the tick that takes the count from 00:01 to 00:00 also moves the state to EXPIRED, all on the same edge.
- done pulses for exactly that one cycle.
- expired stays high until a load or reset.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load latency: digits show the loaded value on the edge that samples load. Clamped values appear with the same latency.
- Start latency: running rises on the edge that samples start.
- First decrement occurs TICK_DIV cycles after a start from IDLE.
- Subsequent decrements occur every TICK_DIV cycles while in RUN.
- Pause/resume: total RUN cycles between decrements always equals TICK_DIV.
- Counting from N seconds to 00:00 takes N·TICK_DIV RUN cycles.
- done is asserted together with the 00:00 digits and expired=1. It is low on the next cycle.
- Reset is asynchronous: asserting rst mid-RUN immediately zeroes all outputs and the FSM. On the first edge after rst deasserts, the block samples its inputs from IDLE.
- Maximum count: 59:59, which is 3599 ticks.

## Test plan
- TICK_DIV=4; load 01:00, start. Required: 00:59 after 4 cycles; 00:00 after 240 cycles; done high for one cycle; expired=1; running=0.
- Borrow chain: load 10:00, start. Required: first tick gives 09:59; load 00:10 then run gives 00:09 on the first tick.
- Load 0xF/7/0xF/7. Required: digits read 5,9,5,9 (59:59).
- Start with 00:00 loaded. Required: state stays IDLE; running=0; done never asserts.
- Pause 2 cycles after start, wait 10 cycles, resume. Required: first decrement occurs exactly 2 cycles after resume. pause+tick in the same cycle gives no decrement.
- Simultaneous pause+start in PAUSE gives no change. Load+start in IDLE loads only and stays IDLE. In EXPIRED, start is ignored and load 00:05 returns to IDLE.
- Drop rst mid-RUN at 03:27. Required: outputs zero asynchronously, before the next clk edge; FSM in IDLE.
